// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared state encoding and counter widths for the fetch hazard controller
package fetch_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN       = 2'd0,
      ST_IMEM_WAIT = 2'd1,
      ST_FLUSH     = 2'd2
   } state_t;

   localparam int REG_ADDR_W_DEF = 5;
   localparam int FLUSH_CNT_W    = 4;
   localparam int WAIT_CNT_W     = 8;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard compare between ID sources and EX load destination
module load_use_detect
   import fetch_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
   input  logic                  i_ex_mem_read,
   input  logic [REG_ADDR_W-1:0] i_ex_rd,
   input  logic [REG_ADDR_W-1:0] i_id_rs1,
   input  logic [REG_ADDR_W-1:0] i_id_rs2,
   input  logic                  i_id_uses_rs1,
   input  logic                  i_id_uses_rs2,
   output logic                  o_load_use
);

   logic w_rs1_hit;
   logic w_rs2_hit;

   assign w_rs1_hit  = i_id_uses_rs1 && (i_id_rs1 == i_ex_rd);
   assign w_rs2_hit  = i_id_uses_rs2 && (i_id_rs2 == i_ex_rd);
   // x0 is hardwired zero, so a load targeting it never creates a dependency
   assign o_load_use = i_ex_mem_read && (i_ex_rd != '0) && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/fetch_hazard_ctrl.sv
// rtl/fetch_hazard_ctrl.sv - PC / IF/ID / ID/EX sequencing for redirects, load-use stalls and imem waits
// Optional FETCH_CTRL_PERF_EN adds stall_cnt and flush_cnt_total performance counters.
module fetch_hazard_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W   = REG_ADDR_W_DEF,
   parameter int FLUSH_CYCLES = 1,
   parameter int IMEM_TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  imem_req,
   input  logic                  imem_ready,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_uses_rs1,
   input  logic                  id_uses_rs2,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_mem_read,
   input  logic                  ex_branch_taken,
   output logic                  pc_en,
   output logic                  ifid_en,
   output logic                  ifid_flush,
   output logic                  idex_flush,
`ifdef FETCH_CTRL_PERF_EN
   output logic [31:0]           stall_cnt,
   output logic [31:0]           flush_cnt_total,
`endif
   output logic                  timeout_err
);

   localparam logic [FLUSH_CNT_W-1:0] FLUSH_V   = FLUSH_CNT_W'(FLUSH_CYCLES);
   localparam logic [WAIT_CNT_W-1:0]  TIMEOUT_V = WAIT_CNT_W'(IMEM_TIMEOUT);

   logic                   w_load_use;
   state_t                 r_state, w_state_nxt;
   logic [FLUSH_CNT_W-1:0] r_flush_cnt, w_flush_nxt;
   logic [WAIT_CNT_W-1:0]  r_wait_cnt, w_wait_nxt;
   logic                   r_timeout_err;

   load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_load_use_detect (
      .i_ex_mem_read (ex_mem_read),
      .i_ex_rd       (ex_rd),
      .i_id_rs1      (id_rs1),
      .i_id_rs2      (id_rs2),
      .i_id_uses_rs1 (id_uses_rs1),
      .i_id_uses_rs2 (id_uses_rs2),
      .o_load_use    (w_load_use)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_RUN;
         r_flush_cnt   <= '0;
         r_wait_cnt    <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_flush_cnt <= w_flush_nxt;
         r_wait_cnt  <= w_wait_nxt;
         if (w_wait_nxt == TIMEOUT_V)
            r_timeout_err <= 1'b1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_flush_nxt = r_flush_cnt;
      w_wait_nxt  = r_wait_cnt;
      if (ex_branch_taken) begin
         w_flush_nxt = FLUSH_V;
         w_state_nxt = (FLUSH_V != '0) ? ST_FLUSH : ST_RUN;
         w_wait_nxt  = '0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (!w_load_use && imem_ready) begin
                  w_wait_nxt = '0;
               end else if (!w_load_use) begin
                  w_state_nxt = ST_IMEM_WAIT;
                  w_wait_nxt  = WAIT_CNT_W'(1);
               end
            end
            ST_IMEM_WAIT: begin
               // a pending load-use hazard keeps us waiting even if imem answers
               if (!w_load_use && imem_ready) begin
                  w_state_nxt = ST_RUN;
                  w_wait_nxt  = '0;
               end else if (r_wait_cnt != TIMEOUT_V) begin
                  w_wait_nxt = r_wait_cnt + WAIT_CNT_W'(1);
               end
            end
            ST_FLUSH: begin
               if (imem_ready) begin
                  w_flush_nxt = (r_flush_cnt != '0) ? r_flush_cnt - FLUSH_CNT_W'(1) : '0;
                  if (r_flush_cnt <= FLUSH_CNT_W'(1))
                     w_state_nxt = ST_RUN;
               end
            end
            default: w_state_nxt = ST_RUN;
         endcase
      end
   end

   always_comb begin
      imem_req   = 1'b1;
      pc_en      = 1'b0;
      ifid_en    = 1'b1;
      ifid_flush = 1'b1;
      idex_flush = 1'b0;
      if (rst) begin
         imem_req   = 1'b0;
         idex_flush = 1'b1;
      end else if (ex_branch_taken) begin
         pc_en      = 1'b1;
         idex_flush = 1'b1;
      end else if (r_state == ST_FLUSH) begin
         pc_en = imem_ready;
      end else if (w_load_use) begin
         ifid_en    = 1'b0;
         ifid_flush = 1'b0;
         idex_flush = 1'b1;
      end else if (imem_ready) begin
         pc_en      = 1'b1;
         ifid_flush = 1'b0;
      end
   end

   assign timeout_err = r_timeout_err;

`ifdef FETCH_CTRL_PERF_EN
   logic w_stall_evt;

   assign w_stall_evt = !rst && !ex_branch_taken &&
                        ((r_state != ST_FLUSH && w_load_use) || r_state == ST_IMEM_WAIT);

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt       <= '0;
         flush_cnt_total <= '0;
      end else begin
         if (w_stall_evt)
            stall_cnt <= stall_cnt + 32'd1;
         if (ifid_flush)
            flush_cnt_total <= flush_cnt_total + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// tb/tb_fetch_hazard_ctrl.sv - directed and randomized self-checking bench for fetch_hazard_ctrl
module tb_fetch_hazard_ctrl;

   localparam int AW       = 5;
   localparam int FLUSH_N  = 1;
   localparam int TIMEOUT  = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          imem_req;
   logic          imem_ready;
   logic [AW-1:0] id_rs1, id_rs2, ex_rd;
   logic          id_uses_rs1, id_uses_rs2;
   logic          ex_mem_read, ex_branch_taken;
   logic          pc_en, ifid_en, ifid_flush, idex_flush, timeout_err;
`ifdef FETCH_CTRL_PERF_EN
   logic [31:0]   stall_cnt, flush_cnt_total;
`endif

   int n_checks = 0;
   int n_errors = 0;

   // reference model: cycles of flush left, whether a fetch is outstanding, how long it has waited
   int m_flush_left = 0;
   bit m_waiting    = 0;
   int m_wait_len   = 0;
   bit m_terr       = 0;

   always #5 clk = ~clk;

   fetch_hazard_ctrl #(.REG_ADDR_W(AW), .FLUSH_CYCLES(FLUSH_N), .IMEM_TIMEOUT(TIMEOUT)) dut (
      .clk             (clk),
      .rst             (rst),
      .imem_req        (imem_req),
      .imem_ready      (imem_ready),
      .id_rs1          (id_rs1),
      .id_rs2          (id_rs2),
      .id_uses_rs1     (id_uses_rs1),
      .id_uses_rs2     (id_uses_rs2),
      .ex_rd           (ex_rd),
      .ex_mem_read     (ex_mem_read),
      .ex_branch_taken (ex_branch_taken),
      .pc_en           (pc_en),
      .ifid_en         (ifid_en),
      .ifid_flush      (ifid_flush),
      .idex_flush      (idex_flush),
`ifdef FETCH_CTRL_PERF_EN
      .stall_cnt       (stall_cnt),
      .flush_cnt_total (flush_cnt_total),
`endif
      .timeout_err     (timeout_err)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // one clock: drive inputs on negedge, check outputs 1ns later, advance model
   task automatic step(input bit r, input bit br, input bit mr, input int rd,
                       input int rs1, input int rs2, input bit u1, input bit u2, input bit rdy);
      bit lu;
      bit e_req, e_pc, e_en, e_ff, e_xf;
      @(negedge clk);
      rst = r; ex_branch_taken = br; ex_mem_read = mr; ex_rd = AW'(rd);
      id_rs1 = AW'(rs1); id_rs2 = AW'(rs2); id_uses_rs1 = u1; id_uses_rs2 = u2; imem_ready = rdy;
      #1;
      lu = mr && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
      e_req = 1; e_pc = 0; e_en = 1; e_ff = 1; e_xf = 0;
      if (r) begin
         e_req = 0; e_xf = 1;
      end else if (br) begin
         e_pc = 1; e_xf = 1;
      end else if (m_flush_left > 0) begin
         e_pc = rdy;
      end else if (lu) begin
         e_en = 0; e_ff = 0; e_xf = 1;
      end else if (rdy) begin
         e_pc = 1; e_ff = 0;
      end
      check_eq("imem_req", imem_req, e_req);
      check_eq("pc_en", pc_en, e_pc);
      check_eq("ifid_en", ifid_en, e_en);
      check_eq("ifid_flush", ifid_flush, e_ff);
      check_eq("idex_flush", idex_flush, e_xf);
      check_eq("timeout_err", timeout_err, m_terr);
      if (r) begin
         m_flush_left = 0; m_waiting = 0; m_wait_len = 0; m_terr = 0;
      end else if (br) begin
         m_flush_left = FLUSH_N; m_waiting = 0; m_wait_len = 0;
      end else if (m_flush_left > 0) begin
         if (rdy) m_flush_left--;
      end else if (!lu && rdy) begin
         m_waiting = 0; m_wait_len = 0;
      end else if (!lu || m_waiting) begin
         m_waiting = 1;
         if (m_wait_len < TIMEOUT) m_wait_len++;
         if (m_wait_len == TIMEOUT) m_terr = 1;
      end
   endtask

   task automatic idle(input bit rdy);
      step(0, 0, 0, 0, 0, 0, 0, 0, rdy);
   endtask

   initial begin
      rst = 1; ex_branch_taken = 0; ex_mem_read = 0; ex_rd = '0; id_rs1 = '0; id_rs2 = '0;
      id_uses_rs1 = 0; id_uses_rs2 = 0; imem_ready = 0;
      @(posedge clk);
      // reset held two cycles, then normal fetch
      step(1, 0, 0, 0, 0, 0, 0, 0, 1);
      step(1, 1, 1, 5, 5, 5, 1, 1, 0);
      idle(1);
      idle(1);
      // load-use on rs2, then x0 destination must not stall
      step(0, 0, 1, 5, 0, 5, 0, 1, 1);
      idle(1);
      step(0, 0, 1, 0, 0, 0, 1, 1, 1);
      step(0, 0, 1, 7, 7, 3, 0, 1, 1);
      // redirect with one flush cycle
      step(0, 1, 0, 0, 0, 0, 0, 0, 1);
      idle(1);
      idle(1);
      // short imem wait
      for (int i = 0; i < 3; i++) idle(0);
      idle(1);
      idle(1);
      // long wait reaching timeout, sticky through ready, cleared by reset
      for (int i = 0; i < TIMEOUT + 2; i++) idle(0);
      idle(1);
      idle(1);
      step(1, 0, 0, 0, 0, 0, 0, 0, 1);
      idle(1);
      // redirect beats load-use and imem not ready
      step(0, 1, 1, 3, 3, 0, 1, 0, 0);
      step(0, 0, 1, 3, 3, 0, 1, 0, 0);
      step(0, 0, 1, 3, 3, 0, 1, 0, 1);
      step(0, 0, 1, 3, 3, 0, 1, 0, 1);
      idle(1);
      // load-use while in imem wait holds until hazard clears
      idle(0);
      step(0, 0, 1, 2, 2, 0, 1, 0, 1);
      idle(1);
      idle(1);
      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         step($urandom_range(0, 199) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 1),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) != 0);
      end
      for (int i = 0; i < TIMEOUT + 1; i++)
         step(0, 0, 1, 1, $urandom_range(0, 3), 2, $urandom_range(0, 1), 0, 0);
      idle(1);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
